// File: rtl/pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// Tracks the instructions that have left decode (entry 0 = EX, 1 = MEM,
// 2 = WB, ...). From that history it produces:
//   * a load-use stall for the instruction sitting in decode, and
//   * operand-forwarding selects for the instruction currently in EX.
//
// Parameters
//   REG_AW     register address width
//   DEPTH      number of tracked stages after decode (2..8)
//   LOAD_STAGE first entry index whose load data can be forwarded
//              (1..DEPTH-1)
//   ZERO_REG   hard-wired zero register, never a hazard or forward source
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears every entry and the counter
//   id_valid     decode stage holds a real instruction
//   id_rn/rm/rd  decode source and destination registers
//   id_rn_used   decode instruction reads rn
//   id_rm_used   decode instruction reads rm
//   id_regwrite  decode instruction writes rd
//   id_memread   decode instruction is a load
//   flush        kill the decode instruction this cycle
//   stall        hold PC and IF/ID, insert a bubble into EX
//   fwd_a/fwd_b  EX operand source: 0 = register file, k = result of entry k
//   stall_count  saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned ZERO_REG   = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic [15:0]       stall_count
);

    localparam logic [REG_AW-1:0] ZREG = REG_AW'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
        logic              rn_used;
        logic              rm_used;
        logic              regwrite;
        logic              memread;
    } entry_t;

    entry_t      ent_q [DEPTH];
    entry_t      ent_d [DEPTH];
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        hazard;

    // -----------------------------------------------------------------------
    // Load-use detection: a load whose data is not yet forwardable
    // (entry index below LOAD_STAGE) feeding a register the decode
    // instruction actually reads.
    // -----------------------------------------------------------------------
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < LOAD_STAGE; k++) begin
            if (ent_q[k].valid && ent_q[k].memread && (ent_q[k].rd != ZREG)) begin
                if ((id_rn_used && (ent_q[k].rd == id_rn)) ||
                    (id_rm_used && (ent_q[k].rd == id_rm))) begin
                    hazard = 1'b1;
                end
            end
        end
        // flush kills the decode instruction, so it can never be stalled
        stall = id_valid && !flush && hazard;
    end

    // -----------------------------------------------------------------------
    // Forwarding select for the EX instruction (entry 0). Scanning from the
    // oldest entry down lets the youngest matching producer overwrite any
    // older one. Loads still too young to have data are never sources.
    // -----------------------------------------------------------------------
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
            if (ent_q[k].valid && ent_q[k].regwrite && (ent_q[k].rd != ZREG) &&
                !(ent_q[k].memread && (k < LOAD_STAGE + 1))) begin
                if (ent_q[0].valid && ent_q[0].rn_used && (ent_q[k].rd == ent_q[0].rn)) begin
                    fwd_a = k[2:0];
                end
                if (ent_q[0].valid && ent_q[0].rm_used && (ent_q[k].rd == ent_q[0].rm)) begin
                    fwd_b = k[2:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state: shift the history, insert decode or a bubble at entry 0.
    // -----------------------------------------------------------------------
    always_comb begin
        ent_d[0] = '0;
        if (id_valid && !flush && !stall) begin
            ent_d[0].valid    = 1'b1;
            ent_d[0].rd       = id_rd;
            ent_d[0].rn       = id_rn;
            ent_d[0].rm       = id_rm;
            ent_d[0].rn_used  = id_rn_used;
            ent_d[0].rm_used  = id_rm_used;
            ent_d[0].regwrite = id_regwrite;
            ent_d[0].memread  = id_memread;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Directed bench. u_dut uses default parameters; u_sat uses DEPTH=8 and
// LOAD_STAGE=7 so a held load-use pattern stalls 7 of every 8 cycles,
// which reaches counter saturation in a modest number of cycles.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_rn_used, id_rm_used, id_regwrite, id_memread, flush;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       stall;
    logic [2:0] fwd_a, fwd_b;
    logic [15:0] stall_count;

    logic       s_reset;
    logic       s_valid, s_rn_used, s_rm_used, s_regwrite, s_memread, s_flush;
    logic [4:0] s_rn, s_rm, s_rd;
    logic       s_stall;
    logic [2:0] s_fwd_a, s_fwd_b;
    logic [15:0] s_cnt;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    logic [15:0] exp_cnt      = '0;

    always #5 clock = ~clock;

    pipe_hazard_scoreboard u_dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count)
    );

    pipe_hazard_scoreboard #(.DEPTH(8), .LOAD_STAGE(7)) u_sat (
        .clock(clock), .reset(s_reset), .id_valid(s_valid),
        .id_rn(s_rn), .id_rm(s_rm), .id_rd(s_rd),
        .id_rn_used(s_rn_used), .id_rm_used(s_rm_used),
        .id_regwrite(s_regwrite), .id_memread(s_memread),
        .flush(s_flush), .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_count(s_cnt)
    );

    // Drive the decode slot of u_dut.
    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic rnu, input logic rmu,
                          input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
        id_rn_used = rnu; id_rm_used = rmu; id_regwrite = rw; id_memread = mr;
        flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_id(1, 5, 7, 6, 1, 1, 1, 1, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        tests_run++;
        if (fwd_a !== 3'd0) begin tests_failed++; $display("FAIL reset_fwd_a: got %0d expected 0", fwd_a); end
        tests_run++;
        if (fwd_b !== 3'd0) begin tests_failed++; $display("FAIL reset_fwd_b: got %0d expected 0", fwd_b); end
        tests_run++;
        if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        // a reader of X5 right after reset has nothing to wait for
        @(negedge clock);
        set_id(1, 5, 7, 6, 1, 1, 1, 0, 0);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_reader_stall: got %0b expected 0", stall); end
    endtask

    // ADD X1,X2,X3 ; SUB X2,X1,X3
    task automatic test_forward_alu;
        idle(4);
        @(negedge clock); set_id(1, 2, 3, 1, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu_stall_add: got %0b expected 0", stall); end
        @(negedge clock); set_id(1, 1, 3, 2, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu_stall_sub: got %0b expected 0", stall); end
        @(negedge clock); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        tests_run++;
        if (fwd_a !== 3'd1) begin tests_failed++; $display("FAIL alu_fwd_a: got %0d expected 1", fwd_a); end
        tests_run++;
        if (fwd_b !== 3'd0) begin tests_failed++; $display("FAIL alu_fwd_b: got %0d expected 0", fwd_b); end
    endtask

    // LDUR X5,[X10] ; ADD X6,X5,X7
    task automatic test_load_use;
        idle(4);
        @(negedge clock); set_id(1, 10, 0, 5, 1, 0, 1, 1, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL ld_stall_load: got %0b expected 0", stall); end
        @(negedge clock); set_id(1, 5, 7, 6, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL ld_stall_use: got %0b expected 1", stall); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL ld_count_before: got %0d expected %0d", stall_count, exp_cnt); end
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clock); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL ld_stall_release: got %0b expected 0", stall); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL ld_count_after: got %0d expected %0d", stall_count, exp_cnt); end
        @(negedge clock); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        tests_run++;
        if (fwd_a !== 3'd2) begin tests_failed++; $display("FAIL ld_fwd_a: got %0d expected 2", fwd_a); end
        tests_run++;
        if (fwd_b !== 3'd0) begin tests_failed++; $display("FAIL ld_fwd_b: got %0d expected 0", fwd_b); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL ld_count_hold: got %0d expected %0d", stall_count, exp_cnt); end
    endtask

    // ADD X4,X1,X2 ; ADD X4,X1,X2 ; ORR X8,X4,X4
    task automatic test_youngest;
        idle(4);
        @(negedge clock); set_id(1, 1, 2, 4, 1, 1, 1, 0, 0);
        @(negedge clock); set_id(1, 1, 2, 4, 1, 1, 1, 0, 0);
        @(negedge clock); set_id(1, 4, 4, 8, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL young_stall: got %0b expected 0", stall); end
        @(negedge clock); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        tests_run++;
        if (fwd_a !== 3'd1) begin tests_failed++; $display("FAIL young_fwd_a: got %0d expected 1", fwd_a); end
        tests_run++;
        if (fwd_b !== 3'd1) begin tests_failed++; $display("FAIL young_fwd_b: got %0d expected 1", fwd_b); end
    endtask

    // LDUR X31,[X1] ; ADD X31,X31,X31 ; ORR X9,X31,X31
    task automatic test_xzr;
        idle(4);
        @(negedge clock); set_id(1, 1, 0, 31, 1, 0, 1, 1, 0);
        @(negedge clock); set_id(1, 31, 31, 31, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL xzr_stall: got %0b expected 0", stall); end
        @(negedge clock); set_id(1, 31, 31, 9, 1, 1, 1, 0, 0);
        @(negedge clock); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        tests_run++;
        if (fwd_a !== 3'd0) begin tests_failed++; $display("FAIL xzr_fwd_a: got %0d expected 0", fwd_a); end
        tests_run++;
        if (fwd_b !== 3'd0) begin tests_failed++; $display("FAIL xzr_fwd_b: got %0d expected 0", fwd_b); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL xzr_count: got %0d expected %0d", stall_count, exp_cnt); end
    endtask

    // LDUR X5,[X10] ; LDUR X7,[X5] flushed ; ADD X6,X7,X7
    // If the flushed load reached EX, the ADD would stall on X7.
    task automatic test_flush;
        idle(4);
        @(negedge clock); set_id(1, 10, 0, 5, 1, 0, 1, 1, 0);
        @(negedge clock); set_id(1, 5, 0, 7, 1, 0, 1, 1, 1); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %0b expected 0", stall); end
        @(negedge clock); set_id(1, 7, 7, 6, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_bubble: got %0b expected 0", stall); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL flush_count: got %0d expected %0d", stall_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_stall;
        idle(4);
        @(negedge clock); set_id(1, 10, 0, 5, 1, 0, 1, 1, 0);
        @(negedge clock); set_id(1, 5, 7, 6, 1, 1, 1, 0, 0); #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL midrst_stall_before: got %0b expected 1", stall); end
        reset = 1'b1;
        @(negedge clock); reset = 1'b0; #1;
        exp_cnt = '0;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL midrst_stall_after: got %0b expected 0", stall); end
        tests_run++;
        if (stall_count !== exp_cnt) begin tests_failed++; $display("FAIL midrst_count: got %0d expected 0", stall_count); end
        tests_run++;
        if (fwd_a !== 3'd0 || fwd_b !== 3'd0) begin tests_failed++; $display("FAIL midrst_fwd: got %0d/%0d expected 0/0", fwd_a, fwd_b); end
        @(negedge clock); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        tests_run++;
        if (fwd_a !== 3'd0) begin tests_failed++; $display("FAIL midrst_fwd_next: got %0d expected 0", fwd_a); end
    endtask

    // Held LDUR X5,[X5] on u_sat: loads on cycle 0 of each 8, stalls the
    // other 7 while the load walks through entries 0..6.
    task automatic test_saturation;
        s_reset = 1'b1;
        s_valid = 1'b1; s_rn = 5'd5; s_rm = 5'd0; s_rd = 5'd5;
        s_rn_used = 1'b1; s_rm_used = 1'b0; s_regwrite = 1'b1; s_memread = 1'b1; s_flush = 1'b0;
        @(negedge clock);
        @(negedge clock);
        s_reset = 1'b0; #1;
        tests_run++;
        if (s_stall !== 1'b0) begin tests_failed++; $display("FAIL sat_c0_stall: got %0b expected 0", s_stall); end
        for (int i = 1; i <= 74912; i++) begin
            @(negedge clock); #1;
            if (i == 1) begin
                tests_run++;
                if (s_stall !== 1'b1) begin tests_failed++; $display("FAIL sat_c1_stall: got %0b expected 1", s_stall); end
            end
            if (i == 8) begin
                tests_run++;
                if (s_stall !== 1'b0) begin tests_failed++; $display("FAIL sat_c8_stall: got %0b expected 0", s_stall); end
            end
            if (i == 800) begin
                tests_run++;
                if (s_cnt !== 16'd700) begin tests_failed++; $display("FAIL sat_count_800: got %0d expected 700", s_cnt); end
            end
            if (i == 74904) begin
                tests_run++;
                if (s_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_count_max: got %0d expected 65535", s_cnt); end
            end
        end
        tests_run++;
        if (s_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_count_hold: got %0d expected 65535", s_cnt); end
        s_reset = 1'b1;
        @(negedge clock); s_reset = 1'b0; #1;
        tests_run++;
        if (s_cnt !== 16'd0) begin tests_failed++; $display("FAIL sat_reset_count: got %0d expected 0", s_cnt); end
        tests_run++;
        if (s_fwd_a !== 3'd0 || s_fwd_b !== 3'd0) begin tests_failed++; $display("FAIL sat_reset_fwd: got %0d/%0d expected 0/0", s_fwd_a, s_fwd_b); end
        tests_run++;
        if (s_stall !== 1'b0) begin tests_failed++; $display("FAIL sat_reset_stall: got %0b expected 0", s_stall); end
    endtask

    initial begin
        reset = 1'b1;
        s_reset = 1'b1;
        s_valid = 1'b0; s_rn = '0; s_rm = '0; s_rd = '0;
        s_rn_used = 1'b0; s_rm_used = 1'b0; s_regwrite = 1'b0; s_memread = 1'b0; s_flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_forward_alu();
        test_load_use();
        test_youngest();
        test_xzr();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
